// File: rtl/alu_op_sequencer.sv
// Command FIFO + IDLE/EXEC/DONE issue FSM in front of a combinational 4-bit ALU.
// Optional macro ALU_ACC_CHAIN_EN: chained commands take the last handed-off result as A.
module alu_op_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             In_valid,
    output logic             In_ready,
    input  logic [3:0]       In_A,
    input  logic [3:0]       In_B,
    input  logic [2:0]       In_Opcode,
    input  logic             In_Chain,
    output logic [3:0]       ALU_A,
    output logic [3:0]       ALU_B,
    output logic [2:0]       ALU_Opcode,
    input  logic [3:0]       ALU_Result,
    input  logic             ALU_Carry,
    input  logic             ALU_Zero,
    output logic             Out_valid,
    input  logic             Out_ready,
    output logic [3:0]       Out_Result,
    output logic             Out_Carry,
    output logic             Out_Zero,
    output logic             Busy,
    output logic [CNT_W-1:0] Op_count
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OW = PW + 1;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t           state_q;
    logic [3:0]       mem_a_q  [FIFO_DEPTH];
    logic [3:0]       mem_b_q  [FIFO_DEPTH];
    logic [2:0]       mem_op_q [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]    count_q;
    logic [3:0]       alu_a_q, alu_b_q, out_result_q;
    logic [2:0]       alu_op_q;
    logic             out_valid_q, out_carry_q, out_zero_q;
    logic [CNT_W-1:0] op_count_q;
`ifdef ALU_ACC_CHAIN_EN
    logic             mem_ch_q [FIFO_DEPTH];
    logic [3:0]       last_result_q;
`endif

    logic       full, empty, push, pop, out_hs;
    logic [3:0] head_a_d;

    assign full   = (count_q == OW'(FIFO_DEPTH));
    assign empty  = (count_q == '0);
    assign push   = In_valid && !full;
    assign out_hs = (state_q == DONE) && Out_ready;
    assign pop    = !empty && ((state_q == IDLE) || out_hs);

    always_comb begin
        head_a_d = mem_a_q[rd_ptr_q];
`ifdef ALU_ACC_CHAIN_EN
        // Back-to-back pop from DONE happens on the same edge Last_result loads,
        // so forward the result being handed off.
        if (mem_ch_q[rd_ptr_q])
            head_a_d = (state_q == DONE) ? out_result_q : last_result_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q]  <= In_A;
            mem_b_q[wr_ptr_q]  <= In_B;
            mem_op_q[wr_ptr_q] <= In_Opcode;
`ifdef ALU_ACC_CHAIN_EN
            mem_ch_q[wr_ptr_q] <= In_Chain;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_op_q     <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_carry_q  <= 1'b0;
            out_zero_q   <= 1'b0;
            op_count_q   <= '0;
`ifdef ALU_ACC_CHAIN_EN
            last_result_q <= '0;
`endif
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + OW'(1);
                2'b01:   count_q <= count_q - OW'(1);
                default: count_q <= count_q;
            endcase
            if (pop) begin
                alu_a_q  <= head_a_d;
                alu_b_q  <= mem_b_q[rd_ptr_q];
                alu_op_q <= mem_op_q[rd_ptr_q];
            end
            case (state_q)
                IDLE: if (!empty) state_q <= EXEC;
                EXEC: begin
                    out_result_q <= ALU_Result;
                    out_carry_q  <= ALU_Carry;
                    out_zero_q   <= ALU_Zero;
                    out_valid_q  <= 1'b1;
                    state_q      <= DONE;
                end
                DONE: if (Out_ready) begin
                    out_valid_q <= 1'b0;
                    op_count_q  <= op_count_q + CNT_W'(1);
`ifdef ALU_ACC_CHAIN_EN
                    last_result_q <= out_result_q;
`endif
                    state_q     <= empty ? IDLE : EXEC;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign In_ready   = !full;
    assign ALU_A      = alu_a_q;
    assign ALU_B      = alu_b_q;
    assign ALU_Opcode = alu_op_q;
    assign Out_valid  = out_valid_q;
    assign Out_Result = out_result_q;
    assign Out_Carry  = out_carry_q;
    assign Out_Zero   = out_zero_q;
    assign Busy       = (state_q != IDLE) || !empty;
    assign Op_count   = op_count_q;

`ifndef ALU_ACC_CHAIN_EN
    logic unused_chain;
    assign unused_chain = In_Chain;
`endif
endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed + random bench for alu_op_sequencer with a behavioural ALU and an in-order scoreboard.
module tb_alu_op_sequencer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       In_valid = 1'b0, In_ready, In_Chain = 1'b0;
    logic [3:0] In_A = '0, In_B = '0;
    logic [2:0] In_Opcode = '0;
    logic [3:0] ALU_A, ALU_B, ALU_Result;
    logic [2:0] ALU_Opcode;
    logic       ALU_Carry, ALU_Zero;
    logic       Out_valid, Out_ready = 1'b1, Out_Carry, Out_Zero, Busy;
    logic [3:0] Out_Result;
    logic [7:0] Op_count;

    int total = 0;
    int bad   = 0;
    logic [5:0] sb [$];
    logic [3:0] model_last = '0;
    logic [3:0] ea;
    logic [5:0] exp_e;

    always #5 clk = ~clk;

    alu_op_sequencer #(.FIFO_DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .In_valid(In_valid), .In_ready(In_ready), .In_A(In_A), .In_B(In_B),
        .In_Opcode(In_Opcode), .In_Chain(In_Chain),
        .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_Opcode(ALU_Opcode),
        .ALU_Result(ALU_Result), .ALU_Carry(ALU_Carry), .ALU_Zero(ALU_Zero),
        .Out_valid(Out_valid), .Out_ready(Out_ready), .Out_Result(Out_Result),
        .Out_Carry(Out_Carry), .Out_Zero(Out_Zero), .Busy(Busy), .Op_count(Op_count)
    );

    // Returns {zero, carry, result}; SUB carry is the borrow.
    function automatic logic [5:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
        logic [4:0] t;
        case (op)
            3'd0: t = {1'b0, a} + {1'b0, b};
            3'd1: t = {1'b0, a} - {1'b0, b};
            3'd2: t = {1'b0, a & b};
            3'd3: t = {1'b0, a | b};
            3'd4: t = {1'b0, a ^ b};
            3'd5: t = {1'b0, ~a};
            3'd6: t = {a, 1'b0};
            default: t = {a[0], 1'b0, a[3:1]};
        endcase
        return {(t[3:0] == 4'd0), t[4], t[3:0]};
    endfunction

    always_comb {ALU_Zero, ALU_Carry, ALU_Result} = alu_f(ALU_A, ALU_B, ALU_Opcode);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op, input logic ch);
        In_valid = 1'b1; In_A = a; In_B = b; In_Opcode = op; In_Chain = ch;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (Busy && n < 2000) begin tick(); n++; end
        chk(tag, {31'd0, Busy}, 32'd0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, {31'd0, In_ready}, 32'd1);
        chk({tag, "_alu"}, {21'd0, ALU_A, ALU_B, ALU_Opcode}, 32'd0);
        chk({tag, "_out"}, {26'd0, Out_valid, Out_Result, Out_Carry, Out_Zero}, 32'd0);
        chk({tag, "_busy_cnt"}, {23'd0, Busy, Op_count}, 32'd0);
    endtask

    // Scoreboard: compare on output handshake, record expectation on input accept.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            model_last = '0;
        end else begin
            if (Out_valid && Out_ready) begin
                if (sb.size() == 0) chk("unexpected_out", 32'd1, 32'd0);
                else chk("sb_result", {26'd0, Out_Zero, Out_Carry, Out_Result}, {26'd0, sb.pop_front()});
            end
            if (In_valid && In_ready) begin
                ea = In_A;
`ifdef ALU_ACC_CHAIN_EN
                if (In_Chain) ea = model_last;
`endif
                exp_e = alu_f(ea, In_B, In_Opcode);
                model_last = exp_e[3:0];
                sb.push_back(exp_e);
            end
        end
    end

    initial begin
        int acc;
        // Reset state
        repeat (2) @(posedge clk);
        #1 chk_reset("reset");
        rst = 1'b0;

        // Single ADD 9+8 -> 1, carry, idle-pipe latency 2
        drive(4'd9, 4'd8, 3'd0, 1'b0);
        tick(); In_valid = 1'b0;
        chk("t1_lat0_valid", {31'd0, Out_valid}, 32'd0);
        chk("t1_busy", {31'd0, Busy}, 32'd1);
        tick();
        chk("t1_alu_regs", {21'd0, ALU_A, ALU_B, ALU_Opcode}, {21'd0, 4'd9, 4'd8, 3'd0});
        chk("t1_lat1_valid", {31'd0, Out_valid}, 32'd0);
        tick();
        chk("t1_out", {26'd0, Out_valid, Out_Result, Out_Carry, Out_Zero}, {26'd0, 1'b1, 4'd1, 1'b1, 1'b0});
        tick();
        chk("t1_opcount", {24'd0, Op_count}, 32'd1);
        chk("t1_idle", {30'd0, Out_valid, Busy}, 32'd0);

        // SUB 3-5 then XOR 5^5 back-to-back, results 2 cycles apart
        drive(4'd3, 4'd5, 3'd1, 1'b0); tick();
        drive(4'd5, 4'd5, 3'd4, 1'b0); tick();
        In_valid = 1'b0;
        tick();
        chk("t2_sub", {26'd0, Out_valid, Out_Result, Out_Carry, Out_Zero}, {26'd0, 1'b1, 4'hE, 1'b1, 1'b0});
        tick();
        chk("t2_gap", {31'd0, Out_valid}, 32'd0);
        tick();
        chk("t2_xor", {26'd0, Out_valid, Out_Result, Out_Carry, Out_Zero}, {26'd0, 1'b1, 4'h0, 1'b0, 1'b1});
        tick();
        chk("t2_opcount", {24'd0, Op_count}, 32'd3);

        // Capacity with stalled consumer: FIFO_DEPTH + 1 in flight
        Out_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(4'(i + 1), 4'd2, 3'd3, 1'b0);
            if (In_ready) acc++;
            tick();
        end
        In_valid = 1'b0;
        chk("t3_accepted", acc, 32'd5);
        chk("t3_full", {31'd0, In_ready}, 32'd0);
        Out_ready = 1'b1;
        wait_idle("t3_drain_timeout");
        chk("t3_ready", {31'd0, In_ready}, 32'd1);
        chk("t3_sb_empty", sb.size(), 32'd0);
        chk("t3_opcount", {24'd0, Op_count}, 32'd8);

        // Chain: ADD 7+1, then chained ADD B=9
        drive(4'd7, 4'd1, 3'd0, 1'b0); tick();
        drive(4'd0, 4'd9, 3'd0, 1'b1); tick();
        In_valid = 1'b0; In_Chain = 1'b0;
        tick();
        chk("t4_first", {27'd0, Out_valid, Out_Result}, {27'd0, 1'b1, 4'd8});
        tick(); tick();
`ifdef ALU_ACC_CHAIN_EN
        chk("t4_chained", {26'd0, Out_valid, Out_Result, Out_Carry, Out_Zero}, {26'd0, 1'b1, 4'd1, 1'b1, 1'b0});
`else
        chk("t4_unchained", {26'd0, Out_valid, Out_Result, Out_Carry, Out_Zero}, {26'd0, 1'b1, 4'd9, 1'b0, 1'b0});
`endif
        tick();

        // Counter wrap: 256 random ops from reset with random back-pressure
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        acc = 0;
        for (int n = 0; n < 5000 && acc < 256; n++) begin
            drive(4'($urandom), 4'($urandom), 3'($urandom), 1'($urandom));
            Out_ready = 1'($urandom_range(0, 3) != 0);
            if (In_ready) acc++;
            tick();
        end
        In_valid = 1'b0; In_Chain = 1'b0; Out_ready = 1'b1;
        chk("t5_accepted", acc, 32'd256);
        wait_idle("t5_drain_timeout");
        chk("t5_wrap", {24'd0, Op_count}, 32'd0);
        chk("t5_sb_empty", sb.size(), 32'd0);

        // Reset while EXEC with 3 queued
        Out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin drive(4'd1, 4'(i + 2), 3'd0, 1'b0); tick(); end
        In_valid = 1'b0;
        Out_ready = 1'b1; tick(); Out_ready = 1'b0;
        chk("t6_pre_busy", {31'd0, Busy}, 32'd1);
        rst = 1'b1; #1;
        chk_reset("t6_async");
        tick(); rst = 1'b0; Out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t6_no_out", {30'd0, Out_valid, Busy}, 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Command front-end that sits directly upstream of the 4-bit ALU: it accepts opcode/operand commands over a valid/ready handshake, buffers them in a small FIFO, and issues them one at a time to the ALU through registered operand/opcode outputs. It captures the ALU's combinational Result/Carry/Zero into an output register with its own valid/ready handshake and counts completed operations. It isolates the purely combinational ALU from bursty producers and stalling consumers.

## Interface
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2
- CNT_W, 8, width of completed-operation counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- In_valid  in  1  command present
- In_ready  out  1  FIFO can accept (= !full)
- In_A, In_B  in  4 each  operands
- In_Opcode  in  3  ALU opcode (ADD, SUB, AND, OR, XOR, NOT, SHL, SHR = 0..7)
- In_Chain  in  1  use previous result as A (see Configuration)
- ALU_A, ALU_B  out  4 each  registered operands to ALU
- ALU_Opcode  out  3  registered opcode to ALU
- ALU_Result  in  4, ALU_Carry  in  1, ALU_Zero  in  1  ALU outputs
- Out_valid  out  1  captured result available
- Out_ready  in  1  consumer accepts result
- Out_Result  out  4, Out_Carry  out  1, Out_Zero  out  1  captured ALU outputs
- Busy  out  1  FSM not IDLE or FIFO non-empty
- Op_count  out  CNT_W  completed (handed-off) operations

## Operation
- Push when In_valid && In_ready; In_ready depends only on FIFO fullness (a pop in the same cycle does not free a slot for a full-FIFO push).
- FSM states: IDLE, EXEC, DONE.
  - IDLE: FIFO non-empty → pop head into ALU_A/ALU_B/ALU_Opcode, → EXEC; else stay.
  - EXEC: one cycle for ALU to settle; at edge, register ALU_Result/Carry/Zero into Out_*, set Out_valid, → DONE.
  - DONE: hold Out_* and Out_valid until Out_ready. On handshake: Out_valid clears, Op_count increments; if FIFO non-empty pop next head into ALU regs → EXEC (back-to-back), else → IDLE.
- FIFO pointers wrap modulo FIFO_DEPTH; occupancy counter FIFO_DEPTH+1 states; simultaneous push and pop leaves occupancy unchanged.
- Op_count wraps from 2^CNT_W−1 to 0 silently.
- ALU_* registers hold last issued values while not popping.
- Out_* only change at EXEC→DONE; no combinational path In_* → Out_* or Out_ready → In_ready.

## Timing
- Reset values: In_ready=1, ALU_A=0, ALU_B=0, ALU_Opcode=0, Out_valid=0, Out_Result=0, Out_Carry=0, Out_Zero=0, Busy=0, Op_count=0, FSM=IDLE, FIFO empty.
- Idle-pipe latency: command accepted at edge N → ALU_* valid after N+1 → Out_valid high after N+2.
- Sustained throughput with Out_ready=1: one result per 2 cycles.
- Capacity when Out_ready=0: FIFO_DEPTH queued + 1 in flight; In_ready low after FIFO_DEPTH+1 accepts from empty.
- Reset mid-operation: all state and FIFO contents discarded immediately (async), no result emitted.

## Configuration
- ALU_ACC_CHAIN_EN defined: a register Last_result (reset 0) is loaded with Out_Result on every output handshake; on pop, if the entry's In_Chain bit is 1, ALU_A takes Last_result instead of stored A. Chained entry waits in FIFO until prior result handed off (guaranteed by FSM order).
- Not defined: In_Chain ignored and not stored; no Last_result register; ALU_A always stored A.

## Test plan
- Reset, push ADD A=9 B=8, Out_ready=1 → Out_valid 2 cycles after accept, Out_Result=1, Out_Carry=1, Out_Zero=0, Op_count=1.
- Push SUB A=3 B=5, then XOR A=5 B=5 back-to-back → results 4'hE Carry=1 Zero=0, then 0 Carry=0 Zero=1, in order, 2 cycles apart.
- Out_ready=0, push 6 commands from empty → exactly 5 accepted, In_ready low; release Out_ready → all 5 emitted in order, then In_ready=1, Busy=0.
- ALU_ACC_CHAIN_EN: ADD 7+1, then chained ADD B=9 (In_Chain=1, A=0) → 8, then 1 with Carry=1; without macro second result 9.
- Op_count preset path: 256 ops with CNT_W=8 → Op_count wraps to 0.
- Assert rst while in EXEC with 3 queued → all outputs at reset values, no Out_valid afterward without new pushes.
